// File: rtl/mult_signed_iter_pkg.sv
// Shared state encoding, widths and handshake levels for the iterative signed multiplier.
// EX uses the same start/ready levels so both sides agree on polarity.
package mult_signed_iter_pkg;

  localparam int REG_W = 32;

  typedef enum logic [1:0] {
    MULT_IDLE = 2'd0,
    MULT_CALC = 2'd1,
    MULT_DONE = 2'd2
  } mult_state_e;

  localparam logic MULT_START     = 1'b1;
  localparam logic MULT_STOP      = 1'b0;
  localparam logic MULT_READY     = 1'b1;
  localparam logic MULT_NOT_READY = 1'b0;

endpackage

// File: rtl/mult_signed_iter.sv
// Multi-cycle signed DATA_W x DATA_W multiplier for the EX stage.
// It multiplies the operand magnitudes by shift-add, then applies the sign on the last iteration.
module mult_signed_iter
  import mult_signed_iter_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mult_start,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     signed_mult_op1,
  input  logic [DATA_W-1:0]     signed_mult_op2,
  output logic [2*DATA_W-1:0]   signed_mult_result,
  output logic                  mult_finished
);

  localparam int DW = 2 * DATA_W;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    // The most negative value maps to 2^(DATA_W-1), which still fits unsigned.
    return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
  endfunction

  mult_state_e        state_q, state_d;
  logic [DATA_W-1:0]  mcand_q, mplier_q;
  logic [DW-1:0]      acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sign_q;
  logic [DW-1:0]      result_q;
  logic               fin_q;

  logic               go, op_zero, last, load, step;
  logic [DW-1:0]      partial, acc_nxt, prod;
  logic               fin_d, res_we;
  logic [DW-1:0]      res_d;

  assign go      = (mult_start == MULT_START) && !annul_i;
  assign op_zero = (signed_mult_op1 == '0) || (signed_mult_op2 == '0);
  assign last    = (cnt_q == CNT_W'(DATA_W - 1));
  assign load    = (state_q == MULT_IDLE) && go;
  assign step    = (state_q == MULT_CALC) && go;

  assign partial = {{DATA_W{1'b0}}, mcand_q} << cnt_q;
  assign acc_nxt = acc_q + (mplier_q[0] ? partial : '0);
  assign prod    = sign_q ? (~acc_nxt + DW'(1)) : acc_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MULT_IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    if (annul_i) begin
      state_d = MULT_IDLE;
    end else begin
      case (state_q)
        MULT_IDLE: if (mult_start == MULT_START) state_d = op_zero ? MULT_DONE : MULT_CALC;
        MULT_CALC: begin
          if (mult_start == MULT_STOP) state_d = MULT_IDLE;
          else if (last)               state_d = MULT_DONE;
        end
        MULT_DONE: if (mult_start == MULT_STOP) state_d = MULT_IDLE;
        default:   state_d = MULT_IDLE;
      endcase
    end
  end

  // Outputs: finished rises with the result write, either on the last
  // iteration or one cycle after a zero-operand shortcut into DONE.
  always_comb begin
    fin_d  = MULT_NOT_READY;
    res_we = 1'b0;
    res_d  = prod;
    case (state_q)
      MULT_CALC: if (go && last) begin
        fin_d  = MULT_READY;
        res_we = 1'b1;
      end
      MULT_DONE: if (go) begin
        fin_d = MULT_READY;
        if (!fin_q) begin
          res_we = 1'b1;
          res_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
    end else if (load) begin
      mcand_q  <= mag(signed_mult_op1);
      mplier_q <= mag(signed_mult_op2);
      acc_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= signed_mult_op1[DATA_W-1] ^ signed_mult_op2[DATA_W-1];
    end else if (step) begin
      acc_q    <= acc_nxt;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fin_q    <= MULT_NOT_READY;
      result_q <= '0;
    end else begin
      fin_q <= fin_d;
      if (res_we) result_q <= res_d;
    end
  end

  assign mult_finished      = fin_q;
  assign signed_mult_result = result_q;

endmodule
